// File: rtl/led_pattern.sv
// rtl/led_pattern.sv - multi-channel rotating LED pattern sequencer with PWM brightness
// Optional feature macro: LED_PATTERN_PWM_EN (per-channel duty registers and shared PWM counter)
module led_pattern #(
  parameter int                        CHANNELS      = 3,
  parameter int                        PATTERN_BITS  = 8,
  parameter int                        TICK_DIV      = 22,
  parameter int                        PWM_BITS      = 8,
  parameter logic [PATTERN_BITS-1:0]   RESET_PATTERN = 8'b10010000,
  parameter bit                        INVERT        = 1'b1,
  localparam int                       CHAN_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [CHAN_W-1:0]       load_chan,
  input  logic [PATTERN_BITS-1:0] load_pattern,
  input  logic [PWM_BITS-1:0]     load_duty,
  output logic [CHANNELS-1:0]     led_n
);

  logic [TICK_DIV-1:0]     prescaler;
  logic                    tick;
  logic                    load_fire;
  logic [PATTERN_BITS-1:0] pattern [CHANNELS];
  logic [CHANNELS-1:0]     lit;

  // A step boundary is the last count of the prescaler; loads are held off then
  assign tick       = &prescaler;
  assign load_ready = !tick;
  assign load_fire  = load_valid && load_ready;

  // Free-running step prescaler, wraps every 2^TICK_DIV clocks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + TICK_DIV'(1);
    end
  end

  // Pattern registers: a load restarts one channel, a tick rotates all of them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pattern[i] <= RESET_PATTERN;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load_fire && (load_chan == CHAN_W'(i))) begin
          pattern[i] <= load_pattern;
        end else if (tick) begin
          pattern[i] <= {pattern[i][0], pattern[i][PATTERN_BITS-1:1]};
        end
      end
    end
  end

`ifdef LED_PATTERN_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty [CHANNELS];

  // Shared PWM ramp, independent of the step prescaler
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Per-channel duty, replaced together with that channel's pattern
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty[i] <= '1;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load_fire && (load_chan == CHAN_W'(i))) begin
          duty[i] <= load_duty;
        end
      end
    end
  end

  // Lit while the active bit is set and the ramp is below the duty
  always_comb begin
    lit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lit[i] = pattern[i][0] && (pwm_cnt < duty[i]);
    end
  end
`else
  logic unused_load_duty;
  assign unused_load_duty = ^load_duty;

  // Without brightness control the active bit drives the LED directly
  always_comb begin
    lit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lit[i] = pattern[i][0];
    end
  end
`endif

  // Registered pad drive with optional active-low polarity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_n <= {CHANNELS{INVERT}};
    end else begin
      led_n <= lit ^ {CHANNELS{INVERT}};
    end
  end

endmodule

// File: tb/tb_led_pattern.sv
// tb/tb_led_pattern.sv - self-checking bench for led_pattern
module tb_led_pattern;

  localparam int         CH  = 3;
  localparam int         PB  = 8;
  localparam int         TD  = 2;
  localparam int         PWB = 2;
  localparam logic [7:0] RP  = 8'b10010000;
  localparam bit         INV = 1'b1;
  localparam int         P   = 1 << TD;
  localparam int         PW  = 1 << PWB;
`ifdef LED_PATTERN_PWM_EN
  localparam bit PWM_ON = 1'b1;
`else
  localparam bit PWM_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [1:0] load_chan = '0;
  logic [7:0] load_pattern = '0;
  logic [1:0] load_duty = '0;
  logic [2:0] led_n;

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;

  led_pattern #(
    .CHANNELS(CH), .PATTERN_BITS(PB), .TICK_DIV(TD), .PWM_BITS(PWB),
    .RESET_PATTERN(RP), .INVERT(INV)
  ) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_chan(load_chan), .load_pattern(load_pattern), .load_duty(load_duty),
    .led_n(led_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: clocks since reset, rotation steps since last load, plain arithmetic
  int         cyc;
  logic [7:0] m_pat [CH];
  int         m_steps [CH];
  int         m_duty [CH];
  logic [2:0] exp_led;

  always @(posedge clk or posedge reset) begin
    logic [2:0] nxt;
    bit         tk;
    int         pwm;
    bit         on;
    if (reset) begin
      cyc = 0;
      for (int i = 0; i < CH; i++) begin
        m_pat[i] = RP;
        m_steps[i] = 0;
        m_duty[i] = PW - 1;
      end
      exp_led = {CH{INV}};
    end else begin
      tk  = (cyc % P) == (P - 1);
      pwm = cyc % PW;
      for (int i = 0; i < CH; i++) begin
        on = m_pat[i][m_steps[i] % PB] && (!PWM_ON || (pwm < m_duty[i]));
        nxt[i] = on ^ INV;
      end
      if (load_valid && !tk && (int'(load_chan) < CH)) begin
        m_pat[load_chan] = load_pattern;
        m_steps[load_chan] = 0;
        m_duty[load_chan] = int'(load_duty);
      end
      if (tk) begin
        for (int i = 0; i < CH; i++) m_steps[i] = m_steps[i] + 1;
      end
      cyc = cyc + 1;
      exp_led = nxt;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("led_n_model", {5'b0, led_n}, {5'b0, exp_led});
      chk("load_ready_model", {7'b0, load_ready}, {7'b0, ((cyc % P) != (P - 1))});
    end
  end

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while (((cyc % P) != ph) && (n < 8)) begin
      @(negedge clk);
      n++;
    end
    if ((cyc % P) != ph) begin
      checks++;
      failures++;
      $display("FAIL wait_phase actual=%0d required=%0d", cyc % P, ph);
    end
  endtask

  initial begin
    logic [7:0] seq;
    logic       exp_d0;
    seq    = 8'b10110111;
    exp_d0 = PWM_ON ? 1'b1 : 1'b0;

    #1 reset = 1'b1;
    #2;
    chk("reset_led", {5'b0, led_n}, 8'h07);
    chk("reset_ready", {7'b0, load_ready}, 8'h01);
    run_cmp = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // Load chan 1 with a single lit bit at full duty
    wait_phase(0);
    load_valid = 1'b1; load_chan = 2'd1; load_pattern = 8'h01; load_duty = 2'b11;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    chk("load_first_lit", {7'b0, led_n[1]}, 8'h00);
    repeat (4) @(negedge clk);
    chk("load_bit1_dark", {7'b0, led_n[1]}, 8'h01);

    // Request held across a tick cycle
    wait_phase(P - 1);
    chk("collision_not_ready", {7'b0, load_ready}, 8'h00);
    load_valid = 1'b1; load_chan = 2'd2; load_pattern = 8'hF0; load_duty = 2'b01;
    @(negedge clk);
    chk("collision_ready_after", {7'b0, load_ready}, 8'h01);
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    chk("collision_loaded_bit0", {7'b0, led_n[2]}, 8'h01);
    repeat (6) @(negedge clk);

    // Out-of-range channel: handshake completes, nothing changes
    wait_phase(1);
    chk("oor_ready", {7'b0, load_ready}, 8'h01);
    load_valid = 1'b1; load_chan = 2'd3; load_pattern = 8'h00; load_duty = 2'b00;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Zero duty on an always-on pattern
    wait_phase(0);
    load_valid = 1'b1; load_chan = 2'd0; load_pattern = 8'hFF; load_duty = 2'b00;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      chk("duty0_led0", {7'b0, led_n[0]}, {7'b0, exp_d0});
      @(negedge clk);
    end

    // Reset in the middle of operation, then the reset pattern rotation
    #2 reset = 1'b1;
    #1;
    chk("midreset_led", {5'b0, led_n}, 8'h07);
    chk("midreset_ready", {7'b0, load_ready}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      chk("rotation_led0", {7'b0, led_n[0]}, {7'b0, seq[j % 8]});
      repeat (4) @(negedge clk);
    end

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
